// File: rtl/pi1_pkg.sv
// -----------------------------------------------------------------------------
// pi1_pkg
// Shared PI1 definitions: bus op encodings, the downconverter FSM state type,
// and a helper deriving a word-address width from a data width
// (bits - clog2(bytes per word)).
// -----------------------------------------------------------------------------
package pi1_pkg;

    localparam logic [1:0] PINOOP = 2'd0;
    localparam logic [1:0] PIWROP = 2'd1;
    localparam logic [1:0] PIRDOP = 2'd2;
    localparam logic [1:0] PIRWOP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } dc_state_e;

    function automatic int pi1_addrbits(input int archbits);
        return archbits - $clog2(archbits / 8);
    endfunction

    localparam int DEF_MARCHBITSZ = 64;
    localparam int DEF_SARCHBITSZ = 32;
    localparam int DEF_MADDRBITSZ = DEF_MARCHBITSZ - $clog2(DEF_MARCHBITSZ / 8);
    localparam int DEF_SADDRBITSZ = DEF_SARCHBITSZ - $clog2(DEF_SARCHBITSZ / 8);

endpackage

// File: rtl/pi1_downconverter_nextbeat.sv
// -----------------------------------------------------------------------------
// pi1_downconverter_nextbeat
// Combinational search for the lowest byte-select slice with index >= i_start
// that has at least one select bit set.
//   i_sel    all byte selects, RATIO slices of SLICEW bits each
//   i_start  first slice index eligible (one bit wider so RATIO is expressible)
//   o_idx    index of the slice found (0 when none)
//   o_vld    a nonzero slice was found
// -----------------------------------------------------------------------------
module pi1_downconverter_nextbeat #(
    parameter  int RATIO  = 2,
    parameter  int SLICEW = 4,
    localparam int RB     = $clog2(RATIO)
) (
    input  logic [RATIO*SLICEW-1:0] i_sel,
    input  logic [RB:0]             i_start,
    output logic [RB-1:0]           o_idx,
    output logic                    o_vld
);

    // Scanning downward lets the lowest qualifying slice win.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int k = RATIO - 1; k >= 0; k--) begin
            if (((RB + 1)'(k) >= i_start) && (|i_sel[k*SLICEW +: SLICEW])) begin
                o_idx = RB'(k);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pi1_downconverter.sv
// -----------------------------------------------------------------------------
// pi1_downconverter
// Wide-to-narrow PI1 bridge. A master request is split into one slave beat per
// nonzero byte-select slice (ascending), read lanes are reassembled into a
// buffer and presented on m_pi1_data_o when the master is released.
//   clk_i / rst_ni      clock, asynchronous active-low reset
//   m_pi1_*             wide master port (op/addr/data/sel in, data/rdy out)
//   m_pi1_mapsz_o       slave map size rescaled to master words
//   s_pi1_*             narrow slave port (op/addr/data/sel out, data/rdy in)
// -----------------------------------------------------------------------------
module pi1_downconverter
    import pi1_pkg::*;
#(
    parameter  int MARCHBITSZ = 64,
    parameter  int SARCHBITSZ = 32,
    localparam int MADDRBITSZ = MARCHBITSZ - $clog2(MARCHBITSZ / 8),
    localparam int SADDRBITSZ = SARCHBITSZ - $clog2(SARCHBITSZ / 8)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              m_pi1_op_i,
    input  logic [MADDRBITSZ-1:0]   m_pi1_addr_i,
    input  logic [MARCHBITSZ-1:0]   m_pi1_data_i,
    output logic [MARCHBITSZ-1:0]   m_pi1_data_o,
    input  logic [MARCHBITSZ/8-1:0] m_pi1_sel_i,
    output logic                    m_pi1_rdy_o,
    output logic [MADDRBITSZ-1:0]   m_pi1_mapsz_o,
    output logic [1:0]              s_pi1_op_o,
    output logic [SADDRBITSZ-1:0]   s_pi1_addr_o,
    output logic [SARCHBITSZ-1:0]   s_pi1_data_o,
    input  logic [SARCHBITSZ-1:0]   s_pi1_data_i,
    output logic [SARCHBITSZ/8-1:0] s_pi1_sel_o,
    input  logic                    s_pi1_rdy_i,
    input  logic [SADDRBITSZ-1:0]   s_pi1_mapsz_i
);

    localparam int RATIO = MARCHBITSZ / SARCHBITSZ;
    localparam int RB    = $clog2(RATIO);
    localparam int SSELW = SARCHBITSZ / 8;

    dc_state_e                r_state;
    dc_state_e                w_state_nxt;
    logic [1:0]               r_op;
    logic [MADDRBITSZ-1:0]    r_addr;
    logic [MARCHBITSZ-1:0]    r_wdata;
    logic [MARCHBITSZ/8-1:0]  r_sel;
    logic [MARCHBITSZ-1:0]    r_buf;
    logic [MARCHBITSZ-1:0]    r_mdata;
    logic [RB-1:0]            r_beat;
    logic [RB-1:0]            r_prev;
    logic                     r_prev_vld;
    logic                     r_empty;

    logic                     w_idle;
    logic                     w_accept;
    logic [MARCHBITSZ/8-1:0]  w_nb_sel;
    logic [RB:0]              w_nb_start;
    logic [RB-1:0]            w_nb_idx;
    logic                     w_nb_vld;
    logic [MARCHBITSZ-1:0]    w_buf_cap;
    logic [SADDRBITSZ-1:0]    w_mapsz_shr;

    // r_empty marks the single busy cycle that follows a request with no
    // active slices, so the master sees one not-ready cycle.
    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && !r_empty && (m_pi1_op_i != PINOOP);

    // One finder serves both the first-beat search on accept (master sel,
    // from slice 0) and the advance search while issuing (held sel).
    assign w_nb_sel   = w_idle ? m_pi1_sel_i : r_sel;
    assign w_nb_start = w_idle ? '0 : ({1'b0, r_beat} + (RB + 1)'(1));

    pi1_downconverter_nextbeat #(
        .RATIO  (RATIO),
        .SLICEW (SSELW)
    ) u_nextbeat (
        .i_sel   (w_nb_sel),
        .i_start (w_nb_start),
        .o_idx   (w_nb_idx),
        .o_vld   (w_nb_vld)
    );

    // The response on s_pi1_data_i belongs to the beat accepted previously.
    always_comb begin
        w_buf_cap = r_buf;
        if (r_prev_vld) begin
            w_buf_cap[r_prev*SARCHBITSZ +: SARCHBITSZ] = s_pi1_data_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept && w_nb_vld) w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (s_pi1_rdy_i && !w_nb_vld) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (s_pi1_rdy_i) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_op       <= PINOOP;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_sel      <= '0;
            r_buf      <= '0;
            r_mdata    <= '0;
            r_beat     <= '0;
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_empty    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_empty <= 1'b0;
                    if (w_accept) begin
                        r_op       <= m_pi1_op_i;
                        r_addr     <= m_pi1_addr_i;
                        r_wdata    <= m_pi1_data_i;
                        r_sel      <= m_pi1_sel_i;
                        r_buf      <= '0;
                        r_beat     <= w_nb_idx;
                        r_prev_vld <= 1'b0;
                        r_empty    <= !w_nb_vld;
                        if (!w_nb_vld && (m_pi1_op_i != PIWROP)) begin
                            r_mdata <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (s_pi1_rdy_i) begin
                        r_buf      <= w_buf_cap;
                        r_prev     <= r_beat;
                        r_prev_vld <= 1'b1;
                        if (w_nb_vld) begin
                            r_beat <= w_nb_idx;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_pi1_rdy_i) begin
                        r_buf      <= w_buf_cap;
                        r_prev_vld <= 1'b0;
                        // Writes still wait for the slave response but keep
                        // the previous read data visible to the master.
                        if (r_op != PIWROP) begin
                            r_mdata <= w_buf_cap;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_pi1_rdy_o  = w_idle && !r_empty;
    assign m_pi1_data_o = r_mdata;

    assign w_mapsz_shr   = s_pi1_mapsz_i >> RB;
    assign m_pi1_mapsz_o = MADDRBITSZ'(w_mapsz_shr);

    assign s_pi1_op_o   = (r_state == ST_ISSUE) ? r_op : PINOOP;
    assign s_pi1_addr_o = SADDRBITSZ'({r_addr, r_beat});
    assign s_pi1_data_o = r_wdata[r_beat*SARCHBITSZ +: SARCHBITSZ];
    assign s_pi1_sel_o  = r_sel[r_beat*SSELW +: SSELW];

endmodule

// File: tb/tb_pi1_downconverter.sv
module tb_pi1_downconverter;
    import pi1_pkg::*;

    localparam int MA  = 61;
    localparam int SA  = 30;
    localparam int MA2 = 124;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // 64 -> 32 instance
    logic [1:0]    m_op;
    logic [MA-1:0] m_addr, m_mapsz;
    logic [63:0]   m_wdata, m_rdata;
    logic [7:0]    m_sel;
    logic          m_rdy;
    logic [1:0]    s_op;
    logic [SA-1:0] s_addr, s_mapsz;
    logic [31:0]   s_wdata, s_rdata;
    logic [3:0]    s_sel;
    logic          s_rdy;

    // 128 -> 32 instance
    logic [1:0]     b_m_op;
    logic [MA2-1:0] b_m_addr, b_m_mapsz;
    logic [127:0]   b_m_wdata, b_m_rdata;
    logic [15:0]    b_m_sel;
    logic           b_m_rdy;
    logic [1:0]     b_s_op;
    logic [SA-1:0]  b_s_addr, b_s_mapsz;
    logic [31:0]    b_s_wdata, b_s_rdata;
    logic [3:0]     b_s_sel;
    logic           b_s_rdy;

    pi1_downconverter #(.MARCHBITSZ(64), .SARCHBITSZ(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m_pi1_op_i(m_op), .m_pi1_addr_i(m_addr), .m_pi1_data_i(m_wdata),
        .m_pi1_data_o(m_rdata), .m_pi1_sel_i(m_sel), .m_pi1_rdy_o(m_rdy),
        .m_pi1_mapsz_o(m_mapsz), .s_pi1_op_o(s_op), .s_pi1_addr_o(s_addr),
        .s_pi1_data_o(s_wdata), .s_pi1_data_i(s_rdata), .s_pi1_sel_o(s_sel),
        .s_pi1_rdy_i(s_rdy), .s_pi1_mapsz_i(s_mapsz)
    );

    pi1_downconverter #(.MARCHBITSZ(128), .SARCHBITSZ(32)) dut128 (
        .clk_i(clk), .rst_ni(rst_n),
        .m_pi1_op_i(b_m_op), .m_pi1_addr_i(b_m_addr), .m_pi1_data_i(b_m_wdata),
        .m_pi1_data_o(b_m_rdata), .m_pi1_sel_i(b_m_sel), .m_pi1_rdy_o(b_m_rdy),
        .m_pi1_mapsz_o(b_m_mapsz), .s_pi1_op_o(b_s_op), .s_pi1_addr_o(b_s_addr),
        .s_pi1_data_o(b_s_wdata), .s_pi1_data_i(b_s_rdata), .s_pi1_sel_o(b_s_sel),
        .s_pi1_rdy_i(b_s_rdy), .s_pi1_mapsz_i(b_s_mapsz)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    typedef struct {
        logic [1:0]    op;
        logic [SA-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    sel;
    } beat_t;

    beat_t         beats_q[$];
    logic [31:0]   resp_q[$];
    logic [SA-1:0] b_addr_q[$];
    logic          manual_rdy = 1'b0;
    logic          manual_val = 1'b1;
    logic          rand_stall = 1'b0;

    function automatic logic [31:0] slv_f(input logic [SA-1:0] a);
        return {a[15:0] ^ 16'h5AC3, a[29:14] ^ 16'h0F0F};
    endfunction

    always @(negedge clk) begin
        #1;
        if (manual_rdy) s_rdy = manual_val;
        else            s_rdy = rand_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(posedge clk) begin
        if (s_rdy === 1'b1 && s_op != PINOOP) begin
            beats_q.push_back('{s_op, s_addr, s_wdata, s_sel});
            if (resp_q.size() > 0) s_rdata <= resp_q.pop_front();
            else                   s_rdata <= slv_f(s_addr);
        end
        if (b_s_rdy === 1'b1 && b_s_op != PINOOP) begin
            b_addr_q.push_back(b_s_addr);
            b_s_rdata <= slv_f(b_s_addr);
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [SA-1:0] sub_addr(input logic [MA-1:0] a, input int lane);
        logic [MA:0] full;
        full = {a, 1'(lane)};
        return full[SA-1:0];
    endfunction

    function automatic logic [63:0] model_rd(input logic [MA-1:0] a, input logic [7:0] s);
        logic [63:0] r;
        r = '0;
        for (int l = 0; l < 2; l++)
            if (s[l*4 +: 4] != 4'h0) r[l*32 +: 32] = slv_f(sub_addr(a, l));
        return r;
    endfunction

    function automatic int active_beats(input logic [7:0] s);
        int n;
        n = 0;
        for (int l = 0; l < 2; l++) if (s[l*4 +: 4] != 4'h0) n++;
        return n;
    endfunction

    task automatic check_beats(input string tag, input logic [1:0] op, input logic [MA-1:0] a,
                               input logic [63:0] d, input logic [7:0] s);
        int    lanes[$];
        beat_t b;
        for (int l = 0; l < 2; l++) if (s[l*4 +: 4] != 4'h0) lanes.push_back(l);
        chk({tag, " beats"}, 128'(beats_q.size()), 128'(lanes.size()));
        for (int i = 0; i < lanes.size() && i < beats_q.size(); i++) begin
            b = beats_q[i];
            chk({tag, " beat"}, {b.op, b.addr, b.data, b.sel},
                {op, sub_addr(a, lanes[i]), d[lanes[i]*32 +: 32], s[lanes[i]*4 +: 4]});
        end
    endtask

    // Starts at a negedge with m_rdy high; returns the cycle index at which
    // m_rdy is next seen high (accept cycle = 0), or -1 on timeout.
    task automatic do_txn(input logic [1:0] op, input logic [MA-1:0] a, input logic [63:0] d,
                          input logic [7:0] s, output int lat);
        beats_q.delete();
        m_op = op; m_addr = a; m_wdata = d; m_sel = s;
        lat = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) m_op = PINOOP;
            if (m_rdy) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) chk("txn timeout", 0, 1);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [MA-1:0] addr;
        logic [63:0]   wdata;
        logic [7:0]    sel;
        logic [31:0]   r0;
        logic [31:0]   r1;
        logic [63:0]   exp;
        int            lat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        int          n;
        logic [63:0] exp_md;
        logic [63:0] rnd;

        tbl[0] = '{PIRDOP, 61'h10, 64'h0, 8'hFF, 32'hAAAA0000, 32'h5555FFFF, 64'h5555FFFF_AAAA0000, 4};
        tbl[1] = '{PIWROP, 61'h7, 64'h11223344_55667788, 8'hF0, 32'h0BAD0BAD, 32'h0, 64'h5555FFFF_AAAA0000, 3};
        tbl[2] = '{PIRDOP, 61'h3, 64'h0, 8'h0F, 32'h12345678, 32'h0, 64'h00000000_12345678, 3};
        tbl[3] = '{PIRWOP, 61'h4, 64'hCAFEBABE_DEADBEEF, 8'h30, 32'h0F0F1234, 32'h0, 64'h0F0F1234_00000000, 3};
        tbl[4] = '{PIRDOP, 61'h9, 64'h0, 8'h00, 32'h0, 32'h0, 64'h0, 2};
        tbl[5] = '{PIRWOP, 61'h1FFF_FFFF_FFFF_FFFF, 64'hA5A5A5A5_5A5A5A5A, 8'h81, 32'hCAFEF00D, 32'h0BADC0DE,
                   64'h0BADC0DE_CAFEF00D, 4};

        rst_n = 1'b0;
        m_op = PINOOP; m_addr = '0; m_wdata = '0; m_sel = '0; s_mapsz = '0;
        b_m_op = PINOOP; b_m_addr = '0; b_m_wdata = '0; b_m_sel = '0; b_s_mapsz = '0; b_s_rdy = 1'b1;
        s_rdata = '0; b_s_rdata = '0;
        repeat (3) @(negedge clk);

        chk("reset rdy", m_rdy, 1'b1);
        chk("reset outputs", {m_rdata, s_op, s_addr, s_wdata, s_sel}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------- table-driven vectors ----------
        foreach (tbl[i]) begin
            n = active_beats(tbl[i].sel);
            resp_q.delete();
            if (n >= 1) resp_q.push_back(tbl[i].r0);
            if (n >= 2) resp_q.push_back(tbl[i].r1);
            do_txn(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].sel, lat);
            check_beats($sformatf("vec%0d", i), tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].sel);
            chk($sformatf("vec%0d latency", i), 128'(lat), 128'(tbl[i].lat));
            chk($sformatf("vec%0d rdata", i), m_rdata, tbl[i].exp);
        end

        // ---------- slave stall during beat 1 ----------
        resp_q.delete();
        resp_q.push_back(32'h11110000);
        resp_q.push_back(32'h2222FFFF);
        beats_q.delete();
        manual_val = 1'b1;
        manual_rdy = 1'b1;
        m_op = PIRDOP; m_addr = 61'h22; m_wdata = 64'hFEDCBA98_76543210; m_sel = 8'hFF;
        @(negedge clk);
        m_op = PINOOP;
        chk("stall beat0", {s_op, s_addr, s_wdata, s_sel}, {PIRDOP, 30'h44, 32'h76543210, 4'hF});
        @(negedge clk);
        manual_val = 1'b0;
        chk("stall beat1", {s_op, s_addr, s_wdata, s_sel}, {PIRDOP, 30'h45, 32'hFEDCBA98, 4'hF});
        for (int i = 3; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("stall hold c%0d", i), {m_rdy, s_op, s_addr, s_wdata, s_sel},
                {1'b0, PIRDOP, 30'h45, 32'hFEDCBA98, 4'hF});
        end
        manual_val = 1'b1;
        lat = -1;
        for (int k = 8; k <= 60; k++) begin
            @(negedge clk);
            if (m_rdy) begin
                lat = k;
                break;
            end
        end
        chk("stall latency", 128'(lat), 128'(9));
        chk("stall rdata", m_rdata, 64'h2222FFFF_11110000);
        manual_rdy = 1'b0;

        // ---------- reset in the middle of ISSUE ----------
        m_op = PIRDOP; m_addr = 61'h30; m_wdata = 64'h0123456789ABCDEF; m_sel = 8'hFF;
        @(negedge clk);
        m_op = PINOOP;
        chk("pre-reset issuing", s_op, PIRDOP);
        rst_n = 1'b0;
        #1;
        chk("mid reset rdy", m_rdy, 1'b1);
        chk("mid reset outputs", {m_rdata, s_op, s_addr, s_wdata, s_sel}, '0);
        resp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        resp_q.push_back(32'h600DF00D);
        resp_q.push_back(32'h87654321);
        do_txn(PIRDOP, 61'h31, 64'h0, 8'hFF, lat);
        check_beats("post-reset", PIRDOP, 61'h31, 64'h0, 8'hFF);
        chk("post-reset latency", 128'(lat), 128'(4));
        chk("post-reset rdata", m_rdata, 64'h87654321_600DF00D);
        exp_md = 64'h87654321_600DF00D;

        // ---------- randomized traffic vs model ----------
        for (int t = 0; t < 40; t++) begin
            logic [1:0]    op;
            logic [MA-1:0] a;
            logic [63:0]   d;
            logic [7:0]    s;
            rand_stall = (t >= 20);
            op  = 2'($urandom_range(1, 3));
            rnd = {$urandom, $urandom};
            a   = rnd[MA-1:0];
            d   = {$urandom, $urandom};
            s   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) s = 8'h00;
            s_mapsz = SA'($urandom);
            resp_q.delete();
            n = active_beats(s);
            do_txn(op, a, d, s, lat);
            check_beats($sformatf("rnd%0d", t), op, a, d, s);
            if (op != PIWROP) exp_md = model_rd(a, s);
            chk($sformatf("rnd%0d rdata", t), m_rdata, exp_md);
            if (!rand_stall) chk($sformatf("rnd%0d latency", t), 128'(lat), 128'(n + 2));
            else             chk($sformatf("rnd%0d latency", t), 128'(lat >= n + 2), 128'(1));
            chk($sformatf("rnd%0d mapsz", t), m_mapsz, MA'(s_mapsz) / 2);
        end
        rand_stall = 1'b0;

        // ---------- 128 -> 32, sparse selects ----------
        b_addr_q.delete();
        b_s_mapsz = 30'h2ABCDEF3;
        b_m_op = PIRDOP; b_m_addr = 124'h5; b_m_sel = 16'hF00F;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) b_m_op = PINOOP;
            if (b_m_rdy) begin
                lat = k;
                break;
            end
        end
        chk("w128 latency", 128'(lat), 128'(4));
        chk("w128 beats", 128'(b_addr_q.size()), 128'(2));
        if (b_addr_q.size() == 2) begin
            chk("w128 beat0 addr", b_addr_q[0], 30'h14);
            chk("w128 beat3 addr", b_addr_q[1], 30'h17);
        end
        chk("w128 rdata", b_m_rdata, {slv_f(30'h17), 64'h0, slv_f(30'h14)});
        chk("w128 mapsz", b_m_mapsz, MA2'(b_s_mapsz) / 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pi1_downconverter.md
# pi1_downconverter

Bridges a wide PI1 initiator to a narrower PI1 target: each master transaction is split into up to RATIO = MARCHBITSZ/SARCHBITSZ sequential slave beats, and the read data is reassembled before the master is released. Beats whose byte-select slice is all-zero are skipped. The block sits between a wide bus (cache/interconnect) and narrow peripherals or memory controllers, and is the mirror of the narrow-to-wide upconverter.

## Interface
- MARCHBITSZ, 64, master data width in bits; must be greater than SARCHBITSZ; both are powers of two and at least 8.
- SARCHBITSZ, 32, slave data width in bits.
- Derived: MADDRBITSZ = MARCHBITSZ - clog2(MARCHBITSZ/8); SADDRBITSZ = SARCHBITSZ - clog2(SARCHBITSZ/8); RATIO; RB = clog2(RATIO).

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- m_pi1_op_i  in  2  master op: NOOP 0, WR 1, RD 2, RW 3.
- m_pi1_addr_i  in  MADDRBITSZ  master word address.
- m_pi1_data_i  in  MARCHBITSZ  master write data.
- m_pi1_data_o  out  MARCHBITSZ  assembled read data, registered.
- m_pi1_sel_i  in  MARCHBITSZ/8  byte selects.
- m_pi1_rdy_o  out  1  high only in IDLE.
- m_pi1_mapsz_o  out  MADDRBITSZ  s_pi1_mapsz_i >> RB (combinational).
- s_pi1_op_o  out  2  slave op.
- s_pi1_addr_o  out  SADDRBITSZ  {held master addr, beat index}, truncated to the low SADDRBITSZ bits.
- s_pi1_data_o  out  SARCHBITSZ  beat slice of held write data.
- s_pi1_data_i  in  SARCHBITSZ  slave read data.
- s_pi1_sel_o  out  SARCHBITSZ/8  beat slice of held sel.
- s_pi1_rdy_i  in  1  slave ready.

## Operation
- PI1 handshake:
  - A request is accepted in a cycle where rdy is high and op != NOOP.
  - Its response data is valid in the next cycle where rdy is high; that same cycle may also accept the next request.
- IDLE:
  - m_pi1_rdy_o = 1; s_pi1_op_o = NOOP.
  - On master accept: latch op, addr, data and sel; clear the read buffer to 0; set the beat index to the first slice with nonzero sel.
  - Go to ISSUE; if no slice has nonzero sel, stay in IDLE after one cycle with m_pi1_rdy_o low. m_pi1_data_o is 0 in that case.
- ISSUE:
  - Drive the latched op and the slices for the current beat.
  - On s_pi1_rdy_i: capture s_pi1_data_i into the lane of the previously issued beat (none before the first beat); advance the beat index to the next nonzero-sel slice.
  - After the last nonzero-sel beat is accepted, go to DRAIN.
- DRAIN:
  - s_pi1_op_o = NOOP.
  - On s_pi1_rdy_i: capture the last lane; load m_pi1_data_o from the buffer; go to IDLE.
- Skipped lanes read as 0.
- WR: data responses are awaited but discarded, and m_pi1_data_o is left unchanged.
- RW is issued per beat and is not atomic across beats.
- Master inputs are ignored while not in IDLE.

## Timing
- Reset values (async on rst_ni low): state IDLE, m_pi1_rdy_o 1, m_pi1_data_o 0, s_pi1_op_o NOOP, s_pi1_addr_o 0, s_pi1_data_o 0, s_pi1_sel_o 0, buffer 0.
- Latency: with N active beats and the slave always ready, accept at cycle 0; beats issue in cycles 1..N; DRAIN in cycle N+1; m_pi1_rdy_o high with data in cycle N+2.
- s_pi1_rdy_i low holds all slave outputs stable and stalls the state.
- The beat index never wraps; only indices 0..RATIO-1 are issued, in ascending order.
- Reset mid-transaction aborts the transaction with no completion to the master; any pending slave response is dropped. The system resets both sides together.

## Structure
- Shared package pi1_pkg holds:
  - op encodings PINOOP/PIWROP/PIRDOP/PIRWOP;
  - the clog2-derived width constants.
- Sub-module pi1_downconverter_nextbeat: combinational finder of the lowest nonzero sel slice with index ≥ a given start index; outputs the index and a valid flag.
- The FSM (IDLE/ISSUE/DRAIN), holding registers and lane buffer live in the top module.

## Test plan
- 64→32, RD addr 0x10, sel 0xFF, slave returns 0xAAAA0000 then 0x5555FFFF:
  - s_pi1_addr_o is 0x20, then 0x21;
  - m_pi1_data_o = 0x5555FFFF_AAAA0000 with m_pi1_rdy_o high at cycle 4.
- WR sel 0xF0, data 0x11223344_55667788:
  - exactly one beat: addr {a,1}, s_pi1_data_o 0x11223344, s_pi1_sel_o 0xF;
  - m_pi1_rdy_o high again at cycle 3.
- RD with sel 0x00: no slave op issued; m_pi1_rdy_o low for one cycle; m_pi1_data_o = 0.
- Slave stall: hold s_pi1_rdy_i low 5 cycles during beat 1. Slave outputs stay stable and completion is delayed by exactly 5 cycles.
- Assert rst_ni low in ISSUE: all outputs return immediately to their reset values; a subsequent RD completes correctly.
- 128→32, sel 0xF00F: beats at indices 0 and 3 only; lanes 1 and 2 read 0; m_pi1_mapsz_o = s_pi1_mapsz_i >> 2.
